// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction queue on the receiving side of the fetch-to-decode handshake.
// It buffers instruction/PC pairs in a DEPTH-entry circular FIFO and presents
// them to decode in order. A control-flow predecode flag is computed once at
// enqueue and stored with each entry. A flush from branch redirection empties
// the queue in one cycle, so wrong-path instructions never reach decode.
//
// Parameters
//   DEPTH        number of entries (power of two, >= 2)
//   PC_W         PC width
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   flush        discard all entries (priority over push and pop)
//   in_valid     fetch presents in_instr / in_pc
//   in_instr     instruction word from fetch
//   in_pc        PC of in_instr
//   in_ready     queue can accept (registered state only)
//   out_valid    head entry valid
//   out_instr    head instruction
//   out_pc       head PC
//   out_is_ctrl  head is branch / JAL / JALR
//   out_ready    decode consumes the head this cycle
//   count        number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_is_ctrl,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Entry storage
    logic [31:0]     instr_q [DEPTH];
    logic [PC_W-1:0] pc_q    [DEPTH];
    logic            ctrl_q  [DEPTH];

    // Pointers and occupancy; pointers wrap naturally modulo DEPTH
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic in_is_ctrl;

    // Handshake status comes from the count register only, so in_ready has
    // no combinational path from out_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign in_is_ctrl = (in_instr[6:0] == OPC_BRANCH) ||
                        (in_instr[6:0] == OPC_JAL)    ||
                        (in_instr[6:0] == OPC_JALR);

    assign out_instr   = instr_q[head_q];
    assign out_pc      = pc_q[head_q];
    assign out_is_ctrl = ctrl_q[head_q];

    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry arrays are deliberately not reset; entries are only
    // observable through head/count, which are reset, so clearing the arrays
    // would cost logic for no visible effect.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_q[tail_q] <= in_instr;
            pc_q[tail_q]    <= in_pc;
            ctrl_q[tail_q]  <= in_is_ctrl;
        end
    end

endmodule
